// File: rtl/sram2p_rd_sched.sv
// Round-robin read scheduler and write forwarder for one sram2p; read data returns in issue order.
// Optional macro SCHED_RAW_STALL_EN: a read colliding with a same-cycle write is held off one cycle.
module sram2p_rd_sched #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 72,
  parameter int NBPIPE    = 3,
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int RSP_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        rd_req_valid,
  input  logic [NREQ*AWIDTH-1:0] rd_req_addr,
  output logic [NREQ-1:0]        rd_req_ready,
  output logic                   rd_rsp_valid,
  input  logic                   rd_rsp_ready,
  output logic [DWIDTH-1:0]      rd_rsp_data,
  output logic [IDW-1:0]         rd_rsp_id,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AWIDTH-1:0]      wr_addr,
  input  logic [DWIDTH-1:0]      wr_data,
  output logic                   mem_enable,
  output logic                   write_enable,
  output logic [AWIDTH-1:0]      write_address,
  output logic [DWIDTH-1:0]      write_data,
  output logic [AWIDTH-1:0]      read_address,
  input  logic [DWIDTH-1:0]      read_data
);
  localparam int SL = NBPIPE + 2;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic              mem_enable_q, mem_enable_d;
  logic              write_enable_q, write_enable_d;
  logic [AWIDTH-1:0] write_address_q, write_address_d;
  logic [DWIDTH-1:0] write_data_q, write_data_d;
  logic [AWIDTH-1:0] read_address_q, read_address_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SL-1:0]     trk_vld_q, trk_vld_d;
  logic [IDW-1:0]    trk_id_q [SL];
  logic [IDW-1:0]    trk_id_d [SL];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [DWIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [IDW-1:0]    fifo_id [RSP_DEPTH];

  logic [CW-1:0]     inflight;
  logic              issue_ok;
  logic              found;
  logic              push;
  logic              pop;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gnt_idx;

  // Credit: every tracked read already owns a FIFO slot; a same-cycle pop is not counted.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SL; i++) inflight = inflight + CW'(trk_vld_q[i]);
    issue_ok = rst_n && ((int'(fifo_cnt_q) + int'(inflight)) < RSP_DEPTH);
  end

  always_comb begin
    elig = rd_req_valid;
`ifdef SCHED_RAW_STALL_EN
    for (int i = 0; i < NREQ; i++) begin
      if (wr_valid && (rd_req_addr[i*AWIDTH +: AWIDTH] == wr_addr)) elig[i] = 1'b0;
    end
`endif
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && issue_ok && elig[(int'(rr_ptr_q) + k) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    if (found) grant = NREQ'(1) << gnt_idx;
  end

  always_comb begin
    mem_enable_d    = 1'b1;
    write_enable_d  = wr_valid;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    if (wr_valid) begin
      write_address_d = wr_addr;
      write_data_d    = wr_data;
    end
    read_address_d = read_address_q;
    rr_ptr_d       = rr_ptr_q;
    if (found) begin
      read_address_d = rd_req_addr[int'(gnt_idx)*AWIDTH +: AWIDTH];
      rr_ptr_d       = IDW'((int'(gnt_idx) + 1) % NREQ);
    end
    trk_vld_d   = {trk_vld_q[SL-2:0], found};
    trk_id_d[0] = gnt_idx;
    for (int i = 1; i < SL; i++) trk_id_d[i] = trk_id_q[i-1];
    // The oldest tracker slot lines up with the cycle the SRAM presents that read's data.
    push       = trk_vld_q[SL-1];
    pop        = rd_rsp_valid && rd_rsp_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_enable_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      read_address_q  <= '0;
      rr_ptr_q        <= '0;
      trk_vld_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
    end else begin
      mem_enable_q    <= mem_enable_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      read_address_q  <= read_address_d;
      rr_ptr_q        <= rr_ptr_d;
      trk_vld_q       <= trk_vld_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

  // Payload storage carries no reset; validity lives in the tracker bits and FIFO count.
  always_ff @(posedge clk) begin
    trk_id_q <= trk_id_d;
    if (push) begin
      fifo_data[wr_ptr_q] <= read_data;
      fifo_id[wr_ptr_q]   <= trk_id_q[SL-1];
    end
  end

  assign rd_req_ready  = grant;
  assign rd_rsp_valid  = (fifo_cnt_q != '0);
  assign rd_rsp_data   = rd_rsp_valid ? fifo_data[rd_ptr_q] : '0;
  assign rd_rsp_id     = rd_rsp_valid ? fifo_id[rd_ptr_q] : '0;
  assign wr_ready      = rst_n;
  assign mem_enable    = mem_enable_q;
  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign read_address  = read_address_q;

endmodule

// File: tb/tb_sram2p_rd_sched.sv
// Bench for sram2p_rd_sched: behavioural sram2p model, directed stimulus, queue scoreboard.
module tb_sram2p_rd_sched;
  localparam int AWIDTH    = 12;
  localparam int DWIDTH    = 72;
  localparam int NBPIPE    = 3;
  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int RSP_DEPTH = 8;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        rd_req_valid;
  logic [NREQ*AWIDTH-1:0] rd_req_addr;
  logic [NREQ-1:0]        rd_req_ready;
  logic                   rd_rsp_valid;
  logic                   rd_rsp_ready;
  logic [DWIDTH-1:0]      rd_rsp_data;
  logic [IDW-1:0]         rd_rsp_id;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [AWIDTH-1:0]      wr_addr;
  logic [DWIDTH-1:0]      wr_data;
  logic                   mem_enable;
  logic                   write_enable;
  logic [AWIDTH-1:0]      write_address;
  logic [DWIDTH-1:0]      write_data;
  logic [AWIDTH-1:0]      read_address;
  logic [DWIDTH-1:0]      read_data;

  sram2p_rd_sched #(
    .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NBPIPE(NBPIPE),
    .NREQ(NREQ), .IDW(IDW), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_id(rd_rsp_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_enable(mem_enable), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram2p model: read-first, NBPIPE+1 cycles from read_address to read_data.
  logic [DWIDTH-1:0] mem   [0:(1<<AWIDTH)-1];
  logic [DWIDTH-1:0] rpipe [0:NBPIPE];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[12'h010] <= 72'hAB;
      mem[12'h020] <= 72'h11;
      mem[12'h030] <= 72'h22;
      for (int i = 0; i < NREQ; i++) mem[AWIDTH'(256 + i)] <= DWIDTH'(4096 + i);
    end else if (mem_enable) begin
      if (write_enable) mem[write_address] <= write_data;
      rpipe[0] <= mem[read_address];
      for (int i = 1; i <= NBPIPE; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign read_data = rpipe[NBPIPE];

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [DWIDTH-1:0] data;
  } exp_t;
  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [DWIDTH-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rd_rsp_valid && rd_rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual id=%0d data=%0h required=none", rd_rsp_id, rd_rsp_data);
      end else begin
        chk("rsp_id", {{(DWIDTH-IDW){1'b0}}, rd_rsp_id}, {{(DWIDTH-IDW){1'b0}}, sb[0].id});
        chk("rsp_data", rd_rsp_data, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; rd_req_valid = '0; rd_req_addr = '0; rd_rsp_ready = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < NREQ; i++) rd_req_addr[i*AWIDTH +: AWIDTH] = AWIDTH'(256 + i);

    @(negedge clk);
    chk("rst_rd_req_ready", rd_req_ready, 0);
    chk("rst_rd_rsp_valid", rd_rsp_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_read_address", read_address, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("run_wr_ready", wr_ready, 1);
    tick();
    @(negedge clk);
    chk("run_mem_enable", mem_enable, 1);

    // All requesters busy, pointer from reset: 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      tick();
      rd_req_valid = '1;
      @(negedge clk);
      chk("rr_grant", rd_req_ready, 1 << (k % 4));
      push_exp(IDW'(k % 4), DWIDTH'(4096 + k % 4));
    end
    tick();
    rd_req_valid = '0;
    repeat (10) tick();

    // Single read of 0x010: response exactly NBPIPE+3 cycles after the grant.
    rd_req_addr[0 +: AWIDTH] = 12'h010;
    tick();
    rd_req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", rd_req_ready, 4'b0001);
    push_exp(0, 72'hAB);
    tick();
    rd_req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t1_latency", rd_rsp_valid, (k == 6));
    end
    rd_req_addr[0 +: AWIDTH] = 12'h100;
    repeat (4) tick();

    // Consumer stalled: eight grants from pointer 1, then no credit.
    for (int k = 0; k < 8; k++) begin
      tick();
      rd_rsp_ready = 1'b0;
      rd_req_valid = '1;
      @(negedge clk);
      chk("t3_grant", rd_req_ready, 1 << ((1 + k) % 4));
      push_exp(IDW'((1 + k) % 4), DWIDTH'(4096 + (1 + k) % 4));
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      chk("t3_stall_ready", rd_req_ready, 0);
      chk("t3_hold_valid", rd_rsp_valid, 1);
      chk("t3_hold_data", rd_rsp_data, 72'h1001);
    end
    tick();
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_pop_no_credit", rd_req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("t3_resume_grant", rd_req_ready, 1 << ((1 + k) % 4));
      push_exp(IDW'((1 + k) % 4), DWIDTH'(4096 + (1 + k) % 4));
    end
    tick();
    rd_req_valid = '0;
    repeat (20) tick();

    // Same-cycle write 0x55 and read of 0x020 by requester 1.
    rd_req_addr[1*AWIDTH +: AWIDTH] = 12'h020;
    tick();
    wr_valid = 1'b1; wr_addr = 12'h020; wr_data = 72'h55;
    rd_req_valid = 4'b0010;
    @(negedge clk);
    chk("t4_wr_ready", wr_ready, 1);
`ifdef SCHED_RAW_STALL_EN
    chk("t4_masked", rd_req_ready, 0);
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_grant", rd_req_ready, 4'b0010);
    push_exp(1, 72'h55);
    chk("t4_we_pulse", write_enable, 1);
    chk("t4_waddr", write_address, 12'h020);
    chk("t4_wdata", write_data, 72'h55);
    tick();
    rd_req_valid = '0;
    @(negedge clk);
    chk("t4_we_off", write_enable, 0);
`else
    chk("t4_grant", rd_req_ready, 4'b0010);
    push_exp(1, 72'h11);
    tick();
    wr_valid = 1'b0;
    rd_req_valid = '0;
    @(negedge clk);
    chk("t4_we_pulse", write_enable, 1);
    chk("t4_waddr", write_address, 12'h020);
    chk("t4_wdata", write_data, 72'h55);
    tick();
    @(negedge clk);
    chk("t4_we_off", write_enable, 0);
`endif
    rd_req_addr[1*AWIDTH +: AWIDTH] = 12'h101;

    // Write 0x77 to 0x030, read it by requester 2 the next cycle.
    rd_req_addr[2*AWIDTH +: AWIDTH] = 12'h030;
    tick();
    wr_valid = 1'b1; wr_addr = 12'h030; wr_data = 72'h77;
    @(negedge clk);
    tick();
    wr_valid = 1'b0;
    rd_req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_grant", rd_req_ready, 4'b0100);
    push_exp(2, 72'h77);
    tick();
    rd_req_valid = '0;
    rd_req_addr[2*AWIDTH +: AWIDTH] = 12'h102;
    repeat (12) tick();

    // Reset with three reads in flight and two queued.
    for (int k = 0; k < 5; k++) begin
      tick();
      rd_rsp_ready = 1'b0;
      rd_req_valid = '1;
      @(negedge clk);
      chk("t5_grant", rd_req_ready, 1 << ((3 + k) % 4));
    end
    tick();
    rd_req_valid = '0;
    tick();
    @(negedge clk);
    chk("t5_queued", rd_rsp_valid, 1);
    tick();
    rst_n = 1'b0;
    rd_req_valid = '1;
    #1;
    chk("t5_rd_req_ready", rd_req_ready, 0);
    chk("t5_rd_rsp_valid", rd_rsp_valid, 0);
    chk("t5_rd_rsp_data", rd_rsp_data, 0);
    chk("t5_rd_rsp_id", rd_rsp_id, 0);
    chk("t5_wr_ready", wr_ready, 0);
    chk("t5_mem_enable", mem_enable, 0);
    chk("t5_write_enable", write_enable, 0);
    chk("t5_write_address", write_address, 0);
    chk("t5_write_data", write_data, 0);
    chk("t5_read_address", read_address, 0);
    repeat (2) tick();
    rd_req_valid = '0;
    rd_rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t5_no_stale", rd_rsp_valid, 0);
    end
    tick();
    rd_req_valid = '1;
    @(negedge clk);
    chk("t5_ptr_restart", rd_req_ready, 4'b0001);
    push_exp(0, 72'h1000);
    tick();
    rd_req_valid = '0;

    for (int w = 0; w < 50 && sb.size() != 0; w++) tick();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
